// File: rtl/ctrl_regseq.sv
// Register-file command sequencer for one SRC output sample frame.
// Steps NSTAGES accumulate stages, then unloads the result and waits for the output handshake.
module ctrl_regseq #(
   parameter int WIDTH    = 3,
   parameter int NSTAGES  = 4,
   parameter int RES_BASE = 1,
   parameter int ERR_BASE = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             calc_done,
   input  logic             uload_ack,
   output logic             en,
   output logic             rf_rw,
   output logic             res_err,
   output logic             get_reg,
   output logic [WIDTH-1:0] result_reg,
   output logic [WIDTH-1:0] error_reg,
   output logic [2:0]       stage,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CALC_INIT   = 3'd1,
      WAIT_CALC   = 3'd2,
      LOAD_ERROR  = 3'd3,
      LOAD_RESULT = 3'd4,
      ULOAD       = 3'd5,
      WAIT_ACK    = 3'd6
   } state_t;

   localparam logic [WIDTH-1:0] RES_INIT   = WIDTH'(RES_BASE);
   localparam logic [WIDTH-1:0] ERR_A      = WIDTH'(ERR_BASE);
   localparam logic [WIDTH-1:0] ERR_B      = WIDTH'(ERR_BASE + 1);
   localparam logic [2:0]       LAST_STAGE = 3'(NSTAGES - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_d, err_d;
   logic [2:0]       stage_d;
   logic             done_d, en_d, rw_d, re_d, gr_d, busy_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         en         <= 1'b0;
         rf_rw      <= 1'b0;
         res_err    <= 1'b0;
         get_reg    <= 1'b0;
         result_reg <= RES_INIT;
         error_reg  <= ERR_A;
         stage      <= 3'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         en         <= en_d;
         rf_rw      <= rw_d;
         res_err    <= re_d;
         get_reg    <= gr_d;
         result_reg <= res_d;
         error_reg  <= err_d;
         stage      <= stage_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      res_d   = result_reg;
      err_d   = error_reg;
      stage_d = stage;
      done_d  = 1'b0;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:       if (start) state_d = CALC_INIT;
            CALC_INIT:  state_d = WAIT_CALC;
            WAIT_CALC:  if (calc_done) state_d = LOAD_ERROR;
            LOAD_ERROR: state_d = LOAD_RESULT;
            LOAD_RESULT: begin
               if (stage == LAST_STAGE) begin
                  state_d = ULOAD;
               end else begin
                  // Error registers ping-pong so the next stage never overwrites the one just written.
                  res_d   = result_reg + WIDTH'(1);
                  err_d   = (error_reg == ERR_A) ? ERR_B : ERR_A;
                  stage_d = stage + 3'd1;
                  state_d = CALC_INIT;
               end
            end
            ULOAD:      state_d = WAIT_ACK;
            WAIT_ACK: begin
               if (uload_ack) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default:    state_d = IDLE;
         endcase
      end
      if (state_d == IDLE) begin
         res_d   = RES_INIT;
         err_d   = ERR_A;
         stage_d = 3'd0;
      end
      // Command outputs are decoded from the next state so they are registered with it.
      en_d   = (state_d == CALC_INIT) || (state_d == LOAD_ERROR) ||
               (state_d == LOAD_RESULT) || (state_d == ULOAD);
      rw_d   = (state_d == CALC_INIT) || (state_d == ULOAD);
      re_d   = (state_d == LOAD_RESULT);
      gr_d   = (state_d == ULOAD);
      busy_d = (state_d != IDLE);
   end

endmodule
